coord_avg_packer: RTL and testbench
===================================

# coord_avg_packer

Upstream feeder for the 32-bit coordinate PIO input port. Accepts raw X/Y position samples from the positioning front end over a valid/ready handshake and averages each batch of 2^SAMPLE_LOG2 samples. Publishes the result as a held, packed word {Y[15:0], X[15:0]} that drives the PIO `in_port` directly. Flags the word stale when no batch completes within a timeout window.

## Interface
- SAMPLE_LOG2, 2, log2 of samples per batch; legal range 0..4.
- TIMEOUT_CYCLES, 50_000_000, cycles without a publish before `coord_stale` asserts; must be ≥ 2.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- sample_valid  in  1  sample_x/sample_y valid this cycle.
- sample_ready  out  1  block accepts the sample this cycle.
- sample_x  in  16  unsigned X.
- sample_y  in  16  unsigned Y.
- coord_out  out  32  {avg_y, avg_x}; held between publishes; wired to PIO `in_port`.
- coord_fresh  out  1  one-cycle pulse on each publish.
- coord_stale  out  1  no publish within TIMEOUT_CYCLES.

## Operation
- Accept occurs when `sample_valid && sample_ready` at a rising edge.
- Accumulators acc_x and acc_y are unsigned, 16+SAMPLE_LOG2 bits wide. A batch counter counts 0..2^SAMPLE_LOG2-1.
- FSM states:
  - ACCUM: `sample_ready`=1. On each accept, add the sample to both accumulators and increment the counter. On the accept that completes the batch, go to PUBLISH.
  - PUBLISH: lasts one cycle. `sample_ready`=0. Load `coord_out` with {acc_y>>SAMPLE_LOG2, acc_x>>SAMPLE_LOG2}. Pulse `coord_fresh`. Clear the accumulators and counter. Clear `coord_stale` and the timeout counter. Return to ACCUM.
- Timeout counter:
  - Increments every cycle and saturates at TIMEOUT_CYCLES.
  - Reloads to 0 in PUBLISH.
  - On the cycle it reaches TIMEOUT_CYCLES: set `coord_stale`, discard the partial batch (accumulators and counter cleared), and leave `coord_out` unchanged.
- If an accept happens on the same cycle as the timeout, the timeout clears the partial batch. That accepted sample becomes sample 0 of a new batch; it is not dropped.
- SAMPLE_LOG2=0: every accepted sample publishes unchanged.
- No back-pressure except the PUBLISH cycle. A producer holding `sample_valid` sees exactly one stall cycle per batch.

## Timing
- Reset values while `reset_n`=0 at an edge:
  - `coord_out`=0, `coord_fresh`=0, `coord_stale`=1, `sample_ready`=0.
  - FSM in ACCUM, accumulators, batch counter and timeout counter all 0.
- `sample_ready`=1 from the first edge with `reset_n`=1.
- Publish latency: batch-completing accept at edge k → PUBLISH during cycle k..k+1 → `coord_out` updated and `coord_fresh`=1 after edge k+1 → `coord_fresh`=0 after edge k+2.
- `coord_stale` deasserts at the same edge `coord_out` updates.
- Reset asserted mid-batch or in PUBLISH aborts everything and returns all state to reset values; no partial publish.
- `coord_out` never changes except at a PUBLISH edge or reset, so the downstream PIO read register always samples a coherent X/Y pair.

## Configuration
- COORD_ROUND_EN defined: before the shift, add 2^(SAMPLE_LOG2-1) to each accumulator (nothing when SAMPLE_LOG2=0). Result is round-half-up. No overflow is possible: max sum + half < 2^(16+SAMPLE_LOG2).
- COORD_ROUND_EN undefined: plain truncating shift (floor).

## Test plan
- Reset release: `coord_out`=0x00000000, `coord_stale`=1, `sample_ready`=1 on the first cycle out of reset. Three idle cycles → no `coord_fresh`.
- SAMPLE_LOG2=2, back-to-back samples X=10,11,12,13 and Y=100,100,100,103:
  - Without COORD_ROUND_EN: `coord_out`=0x0064000B, exactly one `coord_fresh` pulse, `sample_ready`=0 for one cycle, `coord_stale`=0.
  - With COORD_ROUND_EN: `coord_out`=0x0065000C.
- Four samples of X=Y=0xFFFF, with and without COORD_ROUND_EN → `coord_out`=0xFFFFFFFF (no overflow).
- TIMEOUT_CYCLES=20: publish, then two samples, then idle.
  - `coord_stale`=1 twenty cycles after the publish, `coord_out` unchanged.
  - Next four samples X=Y=4 → 0x00040004 (partial batch discarded).
- Sample accepted on the exact timeout cycle, then three more samples of value 8 → published average includes it (first sample X=Y=0 gives 0x00060006).
- `reset_n`=0 for one cycle after three of four samples → outputs at reset values. Four new samples of 1 → `coord_out`=0x00010001.

Source files
------------

// File: rtl/coord_avg_packer.sv
// coord_avg_packer: averages batches of 2^SAMPLE_LOG2 X/Y samples into a held {Y,X} PIO word.
// Optional build macro COORD_ROUND_EN selects round-half-up instead of truncation.
`default_nettype none

module coord_avg_packer #(
   parameter int SAMPLE_LOG2    = 2,
   parameter int TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   output logic [31:0] coord_out,
   output logic        coord_fresh,
   output logic        coord_stale
);

   localparam int AW = 16 + SAMPLE_LOG2;
   localparam int CW = SAMPLE_LOG2 + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST_IDX  = CW'((1 << SAMPLE_LOG2) - 1);
   localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TMAX_PREV = TW'(TIMEOUT_CYCLES - 1);
`ifdef COORD_ROUND_EN
   localparam logic [AW-1:0] HALF = AW'((1 << SAMPLE_LOG2) >> 1);
`else
   localparam logic [AW-1:0] HALF = '0;
`endif

   typedef enum logic [0:0] {
      ACCUM   = 1'b0,
      PUBLISH = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [AW-1:0]   acc_x, acc_y, acc_x_nxt, acc_y_nxt;
   logic [AW-1:0]   base_x, base_y;
   logic [CW-1:0]   cnt, cnt_nxt, base_cnt;
   logic [TW-1:0]   tcnt;
   logic            running;
   logic            accept;
   logic            timeout_hit;
   logic [15:0]     avg_x, avg_y;

   // running holds sample_ready low until the first edge out of reset
   assign sample_ready = running && (state == ACCUM);
   assign accept       = sample_valid && sample_ready;
   assign timeout_hit  = (state == ACCUM) && (tcnt == TMAX_PREV);

   assign avg_x = 16'((acc_x + HALF) >> SAMPLE_LOG2);
   assign avg_y = 16'((acc_y + HALF) >> SAMPLE_LOG2);

   always_comb begin
      state_nxt = state;
      acc_x_nxt = acc_x;
      acc_y_nxt = acc_y;
      cnt_nxt   = cnt;
      // a timeout discards the partial batch, but a sample accepted on the
      // same edge still starts the new batch
      base_x    = timeout_hit ? '0 : acc_x;
      base_y    = timeout_hit ? '0 : acc_y;
      base_cnt  = timeout_hit ? '0 : cnt;
      case (state)
         ACCUM: begin
            acc_x_nxt = base_x;
            acc_y_nxt = base_y;
            cnt_nxt   = base_cnt;
            if (accept) begin
               acc_x_nxt = base_x + AW'(sample_x);
               acc_y_nxt = base_y + AW'(sample_y);
               cnt_nxt   = base_cnt + 1'b1;
               if (base_cnt == LAST_IDX) begin
                  state_nxt = PUBLISH;
               end
            end
         end
         PUBLISH: begin
            acc_x_nxt = '0;
            acc_y_nxt = '0;
            cnt_nxt   = '0;
            state_nxt = ACCUM;
         end
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= ACCUM;
         acc_x       <= '0;
         acc_y       <= '0;
         cnt         <= '0;
         tcnt        <= '0;
         running     <= 1'b0;
         coord_out   <= '0;
         coord_fresh <= 1'b0;
         coord_stale <= 1'b1;
      end else begin
         running     <= 1'b1;
         state       <= state_nxt;
         acc_x       <= acc_x_nxt;
         acc_y       <= acc_y_nxt;
         cnt         <= cnt_nxt;
         coord_fresh <= (state == PUBLISH);
         if (state == PUBLISH) begin
            tcnt        <= '0;
            coord_out   <= {avg_y, avg_x};
            coord_stale <= 1'b0;
         end else if (tcnt != TMAX) begin
            tcnt <= tcnt + 1'b1;
            if (timeout_hit) begin
               coord_stale <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_coord_avg_packer.sv
// Randomized self-checking bench for coord_avg_packer against a batch-level reference model.
`default_nettype none

module tb_coord_avg_packer;

   localparam int L = 2;
   localparam int N = 1 << L;
   localparam int T = 20;
`ifdef COORD_ROUND_EN
   localparam int RND = N / 2;
   localparam logic [31:0] EXP_VEC = 32'h0065000C;
`else
   localparam int RND = 0;
   localparam logic [31:0] EXP_VEC = 32'h0064000B;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic        sample_ready;
   logic [15:0] sample_x = '0;
   logic [15:0] sample_y = '0;
   logic [31:0] coord_out;
   logic        coord_fresh;
   logic        coord_stale;

   coord_avg_packer #(.SAMPLE_LOG2(L), .TIMEOUT_CYCLES(T)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_x     (sample_x),
      .sample_y     (sample_y),
      .coord_out    (coord_out),
      .coord_fresh  (coord_fresh),
      .coord_stale  (coord_stale)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: sums of the current batch, cycles since last publish
   int          m_sx = 0, m_sy = 0, m_cnt = 0, m_since = 0;
   bit          m_pub = 0, m_ready = 0, m_fresh = 0, m_stale = 1;
   logic [31:0] m_out = '0;

   logic [15:0] vx [4] = '{16'd10, 16'd11, 16'd12, 16'd13};
   logic [15:0] vy [4] = '{16'd100, 16'd100, 16'd100, 16'd103};

   function automatic logic [15:0] avg(input int s);
      return 16'((s + RND) / N);
   endfunction

   task automatic step(input bit v, input logic [15:0] x, input logic [15:0] y, output bit acc);
      sample_valid = v;
      sample_x     = x;
      sample_y     = y;
      acc = v && m_ready;
      @(posedge clk);
      if (!reset_n) begin
         m_sx = 0; m_sy = 0; m_cnt = 0; m_since = 0;
         m_pub = 0; m_ready = 0; m_fresh = 0; m_stale = 1; m_out = '0;
         acc = 0;
      end else begin
         if (m_pub) begin
            m_out = {avg(m_sy), avg(m_sx)};
            m_fresh = 1; m_stale = 0; m_since = 0; m_pub = 0;
            m_sx = 0; m_sy = 0; m_cnt = 0;
         end else begin
            m_fresh = 0;
            if (m_since < T) begin
               m_since++;
               if (m_since == T) begin
                  m_stale = 1; m_sx = 0; m_sy = 0; m_cnt = 0;
               end
            end
            if (acc) begin
               m_sx += int'(x); m_sy += int'(y); m_cnt++;
               if (m_cnt == N) m_pub = 1;
            end
         end
         m_ready = !m_pub;
      end
      #1;
   endtask

   task automatic idle();
      bit a;
      step(1'b0, 16'h0, 16'h0, a);
   endtask

   task automatic send(input logic [15:0] x, input logic [15:0] y, output bit ok);
      ok = 0;
      for (int i = 0; i < 4 && !ok; i++) step(1'b1, x, y, ok);
      sample_valid = 1'b0;
   endtask

   task automatic test_reset();
      int fresh_seen = 0;
      reset_n = 1'b0;
      idle(); idle();
      n_checks++; if (coord_out !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 00000000", coord_out); end
      n_checks++; if (coord_stale !== 1'b1) begin n_fail++; $display("FAIL reset_stale: got %b want 1", coord_stale); end
      n_checks++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", sample_ready); end
      n_checks++; if (coord_fresh !== 1'b0) begin n_fail++; $display("FAIL reset_fresh: got %b want 0", coord_fresh); end
      reset_n = 1'b1;
      idle();
      n_checks++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready: got %b want 1", sample_ready); end
      n_checks++; if (coord_out !== 32'h0 || coord_stale !== 1'b1) begin n_fail++; $display("FAIL release_out: got %h/%b want 00000000/1", coord_out, coord_stale); end
      for (int i = 0; i < 3; i++) begin
         idle();
         if (coord_fresh === 1'b1) fresh_seen++;
      end
      n_checks++; if (fresh_seen != 0) begin n_fail++; $display("FAIL idle_fresh: got %0d pulses want 0", fresh_seen); end
   endtask

   task automatic test_back_to_back();
      int idx = 0, stalls = 0, pulses = 0;
      bit a;
      logic [31:0] first_out = 'x;
      for (int c = 0; c < 20 && idx < 8; c++) begin
         if (sample_ready !== 1'b1) stalls++;
         step(1'b1, vx[idx % 4], vy[idx % 4], a);
         if (a) idx++;
         if (coord_fresh === 1'b1) begin
            if (pulses == 0) first_out = coord_out;
            pulses++;
         end
      end
      for (int c = 0; c < 3; c++) begin
         idle();
         if (coord_fresh === 1'b1) pulses++;
      end
      n_checks++; if (idx != 8) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 8", idx); end
      n_checks++; if (first_out !== EXP_VEC) begin n_fail++; $display("FAIL b2b_first_out: got %h want %h", first_out, EXP_VEC); end
      n_checks++; if (coord_out !== EXP_VEC) begin n_fail++; $display("FAIL b2b_out: got %h want %h", coord_out, EXP_VEC); end
      n_checks++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      n_checks++; if (stalls != 1) begin n_fail++; $display("FAIL b2b_stalls: got %0d want 1", stalls); end
      n_checks++; if (coord_stale !== 1'b0) begin n_fail++; $display("FAIL b2b_stale: got %b want 0", coord_stale); end
   endtask

   task automatic test_max_value();
      bit ok;
      for (int i = 0; i < 4; i++) send(16'hFFFF, 16'hFFFF, ok);
      idle();
      n_checks++; if (coord_fresh !== 1'b1) begin n_fail++; $display("FAIL max_fresh: got %b want 1", coord_fresh); end
      n_checks++; if (coord_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL max_out: got %h want ffffffff", coord_out); end
   endtask

   task automatic test_timeout();
      bit ok;
      int e;
      logic [31:0] saved;
      for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), ok);
      idle();
      saved = coord_out;
      n_checks++; if (saved !== m_out) begin n_fail++; $display("FAIL to_publish: got %h want %h", saved, m_out); end
      e = 0;
      send(16'd500, 16'd700, ok); e++;
      send(16'd900, 16'd300, ok); e++;
      while (e < T - 1) begin idle(); e++; end
      n_checks++; if (coord_stale !== 1'b0) begin n_fail++; $display("FAIL to_early_stale: got %b want 0", coord_stale); end
      idle();
      n_checks++; if (coord_stale !== 1'b1) begin n_fail++; $display("FAIL to_stale: got %b want 1", coord_stale); end
      n_checks++; if (coord_out !== saved) begin n_fail++; $display("FAIL to_out_held: got %h want %h", coord_out, saved); end
      for (int i = 0; i < 4; i++) send(16'd4, 16'd4, ok);
      idle();
      n_checks++; if (coord_out !== 32'h00040004) begin n_fail++; $display("FAIL to_discard: got %h want 00040004", coord_out); end
   endtask

   task automatic test_timeout_accept();
      bit ok;
      int e;
      for (int i = 0; i < 4; i++) send(16'd20, 16'd20, ok);
      idle();
      e = 0;
      while (e < T - 1) begin idle(); e++; end
      send(16'd0, 16'd0, ok);
      n_checks++; if (!ok || coord_stale !== 1'b1) begin n_fail++; $display("FAIL toacc_edge: got ok=%b stale=%b want 1/1", ok, coord_stale); end
      for (int i = 0; i < 3; i++) send(16'd8, 16'd8, ok);
      idle();
      n_checks++; if (coord_fresh !== 1'b1 || coord_out !== 32'h00060006) begin n_fail++; $display("FAIL toacc_out: got %h fresh=%b want 00060006/1", coord_out, coord_fresh); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      for (int i = 0; i < 3; i++) send(16'd9, 16'd9, ok);
      reset_n = 1'b0;
      idle();
      reset_n = 1'b1;
      n_checks++; if (coord_out !== 32'h0 || coord_stale !== 1'b1 || sample_ready !== 1'b0 || coord_fresh !== 1'b0)
         begin n_fail++; $display("FAIL midrst_state: got out=%h stale=%b ready=%b fresh=%b want 0/1/0/0", coord_out, coord_stale, sample_ready, coord_fresh); end
      for (int i = 0; i < 4; i++) send(16'd1, 16'd1, ok);
      idle();
      n_checks++; if (coord_out !== 32'h00010001) begin n_fail++; $display("FAIL midrst_out: got %h want 00010001", coord_out); end
   endtask

   task automatic test_random();
      bit a, v;
      int errs = 0;
      for (int c = 0; c < 400; c++) begin
         v = (c < 250) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 1);
         step(v, 16'($urandom), 16'($urandom), a);
         n_checks++;
         if (coord_out !== m_out || coord_fresh !== m_fresh || coord_stale !== m_stale || sample_ready !== m_ready) begin
            n_fail++;
            if (errs++ < 10)
               $display("FAIL rand_cycle%0d: got out=%h fresh=%b stale=%b ready=%b want %h/%b/%b/%b",
                        c, coord_out, coord_fresh, coord_stale, sample_ready, m_out, m_fresh, m_stale, m_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_max_value();
      test_timeout();
      test_timeout_accept();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
